// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one multi-cycle memory between fetch and data ports with fetch anti-starvation
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_FETCH_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int WC_W = $clog2(MEM_LATENCY + 1);
  localparam int SC_W = $clog2(MAX_FETCH_WAIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [WC_W-1:0] wcnt;
  logic [SC_W-1:0] starve;
  logic sel_d, we_q, grant_if, grant_d, last, start;
  always_comb begin
    grant_if = if_req && (!d_req || starve == SC_W'(MAX_FETCH_WAIT));
    grant_d = d_req && !grant_if;
    start = state == IDLE && (if_req || d_req);
    last = wcnt == WC_W'(MEM_LATENCY - 1);
    nxt = state == IDLE ? (start ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT ? (last ? DONE : WAIT) : IDLE;
    mem_en = state == ISSUE;
    mem_we = mem_en && we_q;
    if_ready = state == DONE && !sel_d;
    d_ready = state == DONE && sel_d;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      starve <= '0;
      sel_d <= 1'b0;
      we_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (start) begin
        sel_d <= grant_d;
        we_q <= grant_d && d_we;
        mem_addr <= grant_d ? d_addr : if_addr;
        if (grant_d && d_we) mem_wdata <= d_wdata;
        // data only wins a contested arbitration below the cap, so the increment saturates itself
        starve <= grant_if ? '0 : if_req ? starve + 1'b1 : starve;
      end
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      if (state == WAIT && last && !we_q) begin
        if (sel_d) d_rdata <= mem_rdata;
        else if_rdata <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed tests of arbitration, latency, stores and reset for the unified memory arbiter
module tb_unified_mem_arbiter;
  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ready, d_ready, mem_en, mem_we, busy;
  logic if_req2 = 0, d_req2 = 0, d_we2 = 0;
  logic [31:0] if_addr2 = 0, d_addr2 = 0, d_wdata2 = 0;
  logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic if_ready2, d_ready2, mem_en2, mem_we2, busy2;
  unified_mem_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));
  unified_mem_arbiter #(.MEM_LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ready(if_ready2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2), .d_rdata(d_rdata2), .d_ready(d_ready2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2));
  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'h2000_0000 | (a << 16) | (a << 2);
  endfunction
  // memory models drive valid data only in the cycle issue+latency, garbage otherwise
  logic p1v = 0, p2v = 0, q2v = 0;
  logic [31:0] p1d = 0, p2d = 0, q2d = 0;
  always @(posedge clk) begin
    p1v <= mem_en && !mem_we;
    p1d <= f(mem_addr);
    p2v <= p1v;
    p2d <= p1d;
    q2v <= mem_en2 && !mem_we2;
    q2d <= f(mem_addr2);
  end
  assign mem_rdata = p2v ? p2d : 32'hDEAD_BEEF;
  assign mem_rdata2 = q2v ? q2d : 32'hDEAD_BEEF;
  int n_cmp = 0, n_bad = 0, viol = 0;
  logic hold_if = 0, hold_d = 0;
  int en_cyc[$], if_cyc[$], d_cyc[$], if2_cyc[$], en2_cyc[$];
  logic [31:0] en_addr[$], en_wd[$], if_dat[$], d_dat[$], if2_dat[$];
  logic en_we[$];
  task automatic clear();
    en_cyc.delete(); if_cyc.delete(); d_cyc.delete(); if2_cyc.delete(); en2_cyc.delete();
    en_addr.delete(); en_wd.delete(); if_dat.delete(); d_dat.delete(); if2_dat.delete(); en_we.delete();
  endtask
  task automatic step();
    @(negedge clk);
    if (mem_en) begin
      en_cyc.push_back(cyc); en_addr.push_back(mem_addr); en_we.push_back(mem_we); en_wd.push_back(mem_wdata);
    end
    if (mem_we && !mem_en) viol++;
    if (if_ready && d_ready) viol++;
    if (if_ready) begin
      if_cyc.push_back(cyc); if_dat.push_back(if_rdata);
      if (!hold_if) if_req = 0;
    end
    if (d_ready) begin
      d_cyc.push_back(cyc); d_dat.push_back(d_rdata);
      if (!hold_d) d_req = 0;
    end
    if (mem_en2) en2_cyc.push_back(cyc);
    if (if_ready2) begin
      if2_cyc.push_back(cyc); if2_dat.push_back(if_rdata2); if_req2 = 0;
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we, if_ready, d_ready, busy} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, if_ready, d_ready, busy}); end
    n_cmp++; if (if_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy_lat1: got %b want 0", busy2); end
    reset = 0;
    repeat (2) step();
  endtask
  task automatic test_fetch();
    int t0, rc;
    @(posedge clk); #1;
    if_addr = 32'h8; if_req = 1; t0 = cyc; clear();
    repeat (8) step();
    rc = if_cyc.size() == 1 ? if_cyc[0] - t0 : -1;
    n_cmp++; if (rc !== 4) begin n_bad++; $display("FAIL fetch_ready_cycle: got %0d want 4 (count %0d)", rc, if_cyc.size()); end
    n_cmp++; if (if_dat.size() != 1 || if_dat[0] !== 32'h2008_0020) begin n_bad++; $display("FAIL fetch_data: got %h want 20080020", if_rdata); end
    n_cmp++; if (en_addr.size() != 1 || en_addr[0] !== 32'h8 || en_we[0] !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_en: got %0d strobes want one at 8", en_addr.size()); end
    n_cmp++; if (d_cyc.size() !== 0) begin n_bad++; $display("FAIL fetch_no_d_ready: got %0d want 0", d_cyc.size()); end
    n_cmp++; if (if_rdata !== 32'h2008_0020 || mem_addr !== 32'h8) begin n_bad++; $display("FAIL fetch_hold: got %h/%h want 20080020/8", if_rdata, mem_addr); end
  endtask
  task automatic test_both();
    int t0, rd, ri;
    @(posedge clk); #1;
    if_addr = 32'h0; d_addr = 32'h4; d_we = 0; if_req = 1; d_req = 1; t0 = cyc; clear();
    repeat (14) step();
    n_cmp++; if (en_addr.size() != 2 || en_addr[0] !== 32'h4 || en_addr[1] !== 32'h0) begin n_bad++; $display("FAIL both_order: got %0d strobes want 4 then 0", en_addr.size()); end
    rd = d_cyc.size() == 1 ? d_cyc[0] - t0 : -1;
    ri = if_cyc.size() == 1 ? if_cyc[0] - t0 : -1;
    n_cmp++; if (rd !== 4 || ri !== 9) begin n_bad++; $display("FAIL both_ready_cycles: got d=%0d if=%0d want d=4 if=9", rd, ri); end
    n_cmp++; if (d_dat.size() != 1 || d_dat[0] !== 32'h2004_0010) begin n_bad++; $display("FAIL both_d_data: got %h want 20040010", d_rdata); end
    n_cmp++; if (if_dat.size() != 1 || if_dat[0] !== 32'h2000_0000) begin n_bad++; $display("FAIL both_if_data: got %h want 20000000", if_rdata); end
  endtask
  task automatic test_back_to_back_starve();
    int t0;
    logic [9:0] exp_f;
    exp_f = 10'b10_0001_0000;
    @(posedge clk); #1;
    if_addr = 32'hC; d_addr = 32'h10; d_we = 0; hold_if = 1; hold_d = 1; if_req = 1; d_req = 1; t0 = cyc; clear();
    repeat (50) step();
    if_req = 0; d_req = 0; hold_if = 0; hold_d = 0;
    n_cmp++; if (en_addr.size() !== 10) begin n_bad++; $display("FAIL starve_count: got %0d want 10", en_addr.size()); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (i >= en_addr.size() || en_addr[i] !== (exp_f[i] ? 32'hC : 32'h10)) begin n_bad++; $display("FAIL starve_grant_%0d: got %h want %h", i, i < en_addr.size() ? en_addr[i] : 32'hX, exp_f[i] ? 32'hC : 32'h10); end
    end
    n_cmp++; if (en_cyc.size() != 10 || en_cyc[9] - t0 !== 46) begin n_bad++; $display("FAIL starve_throughput: got last issue %0d want 46", en_cyc.size() == 10 ? en_cyc[9] - t0 : -1); end
    n_cmp++; if (if_cyc.size() !== 2 || d_cyc.size() !== 8) begin n_bad++; $display("FAIL starve_ready_counts: got if=%0d d=%0d want 2/8", if_cyc.size(), d_cyc.size()); end
    n_cmp++; if (if_dat.size() != 2 || if_dat[1] !== 32'h200C_0030 || d_rdata !== 32'h2010_0040) begin n_bad++; $display("FAIL starve_data: got if=%h d=%h want 200c0030/20100040", if_rdata, d_rdata); end
  endtask
  task automatic test_store();
    int t0, rd;
    @(posedge clk); #1;
    d_we = 1; d_addr = 32'h8; d_wdata = 32'h20; d_req = 1; t0 = cyc; clear();
    repeat (8) step();
    d_we = 0;
    n_cmp++; if (en_addr.size() != 1 || en_addr[0] !== 32'h8 || en_we[0] !== 1'b1 || en_wd[0] !== 32'h20) begin n_bad++; $display("FAIL store_strobe: got %0d strobes want one we=1 addr 8 wdata 20", en_addr.size()); end
    rd = d_cyc.size() == 1 ? d_cyc[0] - t0 : -1;
    n_cmp++; if (rd !== 4) begin n_bad++; $display("FAIL store_ready_cycle: got %0d want 4", rd); end
    n_cmp++; if (d_rdata !== 32'h2010_0040) begin n_bad++; $display("FAIL store_d_rdata: got %h want 20100040", d_rdata); end
    n_cmp++; if (mem_wdata !== 32'h20) begin n_bad++; $display("FAIL store_wdata_hold: got %h want 20", mem_wdata); end
  endtask
  task automatic test_reset_mid();
    int t0, rc;
    @(posedge clk); #1;
    if_addr = 32'h14; if_req = 1; t0 = cyc; clear();
    repeat (3) step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_wait: got %b want 1", busy); end
    reset = 1; if_req = 0;
    #1;
    n_cmp++; if ({mem_en, busy, if_ready} !== 3'b0) begin n_bad++; $display("FAIL rmid_async: got %b want 000", {mem_en, busy, if_ready}); end
    repeat (2) @(negedge clk);
    reset = 0; clear();
    repeat (8) step();
    n_cmp++; if (if_cyc.size() !== 0 || en_cyc.size() !== 0) begin n_bad++; $display("FAIL rmid_no_ready: got ready=%0d strobes=%0d want 0/0", if_cyc.size(), en_cyc.size()); end
    @(posedge clk); #1;
    if_addr = 32'h4; if_req = 1; t0 = cyc; clear();
    repeat (8) step();
    rc = if_cyc.size() == 1 ? if_cyc[0] - t0 : -1;
    n_cmp++; if (rc !== 4) begin n_bad++; $display("FAIL rmid_refetch_cycle: got %0d want 4", rc); end
    n_cmp++; if (if_rdata !== 32'h2004_0010) begin n_bad++; $display("FAIL rmid_refetch_data: got %h want 20040010", if_rdata); end
  endtask
  task automatic test_latency1();
    int t0, rc, re;
    @(posedge clk); #1;
    if_addr2 = 32'h8; if_req2 = 1; t0 = cyc; clear();
    repeat (6) step();
    rc = if2_cyc.size() == 1 ? if2_cyc[0] - t0 : -1;
    re = en2_cyc.size() == 1 ? en2_cyc[0] - t0 : -1;
    n_cmp++; if (rc !== 3 || re !== 1) begin n_bad++; $display("FAIL lat1_cycles: got ready=%0d issue=%0d want 3/1", rc, re); end
    n_cmp++; if (if2_dat.size() != 1 || if2_dat[0] !== 32'h2008_0020) begin n_bad++; $display("FAIL lat1_data: got %h want 20080020", if_rdata2); end
  endtask
  task automatic test_invariants();
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL invariants: got %0d violations want 0", viol); end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_both();
    test_back_to_back_starve();
    test_store();
    test_reset_mid();
    test_latency1();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
